// File: rtl/key_scan_mux.sv
// rtl/key_scan_mux.sv - debounced hex key entry into a multiplexed 7-segment display
// Optional feature: define KEY_SCAN_MUX_AUTOREPEAT_EN to auto-repeat a held key_next.
module key_scan_mux #(
  parameter int N_KEY      = 4,
  parameter int N_DIG      = 8,
  parameter int DEB_CYC    = 1000000,
  parameter int SCAN_DIV   = 50000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_KEY-1:0]         key_data,
  input  logic                     key_next,
  input  logic                     key_mode,
  output logic [7:0]               seg,
  output logic [N_DIG-1:0]         dig_sel,
  output logic [$clog2(N_DIG)-1:0] cursor,
  output logic                     mode
);

  localparam int NK     = N_KEY + 2;
  localparam int K_NEXT = N_KEY;
  localparam int DW     = $clog2(DEB_CYC + 1);
  localparam int SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW     = $clog2(N_DIG);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DIG_LAST  = CW'(N_DIG - 1);

  if (N_KEY < 1 || N_KEY > 4 || N_DIG < 2 || N_DIG > 8 || DEB_CYC < 1 ||
      SCAN_DIV < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_param
    $error("key_scan_mux: parameter out of range");
  end

  // Active-low a..g glyphs for hex digits 0-F.
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Raw key vector: data keys low, then key_next, then key_mode.
  logic [NK-1:0] raw;
  assign raw = {key_mode, key_next, key_data};

  logic [NK-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            vld_q, vld_d;
  logic [NK-1:0]         deb_q, deb_d;
  logic [NK-1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]            armed_q, armed_d;
  logic [1:0]            press_q, press_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [CW-1:0]         scan_idx_q, scan_idx_d;
  logic [CW-1:0]         cursor_q, cursor_d;
  logic                  mode_q, mode_d;
  logic [N_DIG-1:0][3:0] digs_q, digs_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIG-1:0]      dig_sel_q, dig_sel_d;
  logic [N_KEY-1:0]      live_inv;
  logic [3:0]            live;
  logic                  rep_pulse;
  logic                  advance;

  // Two-stage synchronizer; vld marks when stage 2 carries real samples after reset.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
  end

  // Debounce: adopt the synchronized level after DEB_CYC consecutive differing cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NK; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Press pulses for next/mode; a key must be seen released after reset before it can fire.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      armed_d[j] = armed_q[j] | (vld_q[1] & sync2_q[K_NEXT+j]);
      press_d[j] = armed_q[j] & deb_q[K_NEXT+j] & ~deb_d[K_NEXT+j];
    end
  end

  // Key front-end registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      vld_q   <= '0;
      deb_q   <= '1;
      cnt_q   <= '0;
      armed_q <= '0;
      press_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

`ifdef KEY_SCAN_MUX_AUTOREPEAT_EN
  localparam int RW = $clog2(((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD) + 1);
  localparam logic [RW-1:0] REP_DELAY_C  = RW'(REP_DELAY);
  localparam logic [RW-1:0] REP_PERIOD_C = RW'(REP_PERIOD);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_act_q, rep_act_d;
  logic          rep_first_q, rep_first_d;

  // Repeat timer: counts cycles since the last advance while key_next stays debounced-low.
  always_comb begin
    rep_pulse   = rep_act_q & ~deb_q[K_NEXT] &
                  (rep_cnt_q == (rep_first_q ? REP_DELAY_C : REP_PERIOD_C));
    rep_cnt_d   = rep_cnt_q + 1'b1;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    if (press_q[0]) begin
      rep_act_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_cnt_d   = RW'(1);
    end else if (!rep_act_q || deb_q[K_NEXT]) begin
      rep_act_d   = 1'b0;
      rep_first_d = 1'b0;
      rep_cnt_d   = '0;
    end else if (rep_pulse) begin
      rep_first_d = 1'b0;
      rep_cnt_d   = RW'(1);
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  // Live value: pressed data keys read as 1, zero-extended to a nibble.
  assign live_inv = ~deb_q[N_KEY-1:0];
  always_comb begin
    live = '0;
    live[N_KEY-1:0] = live_inv;
  end

  // Edit state: store live value at the cursor and advance; toggle view mode.
  always_comb begin
    advance  = press_q[0] | rep_pulse;
    cursor_d = cursor_q;
    digs_d   = digs_q;
    mode_d   = mode_q ^ press_q[1];
    if (advance) begin
      digs_d[cursor_q] = live;
      cursor_d = (cursor_q == DIG_LAST) ? '0 : cursor_q + 1'b1;
    end
  end

  // Scan divider and digit index for the all-digit view.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == DIG_LAST) ? '0 : scan_idx_q + 1'b1;
    end
  end

  // Display drive: scanned stored digits with cursor dp, or the live value on the cursor digit.
  always_comb begin
    logic [CW-1:0] disp_idx;
    logic [3:0]    disp_val;
    disp_idx = mode_q ? scan_idx_q : cursor_q;
    disp_val = mode_q ? digs_q[scan_idx_q] : live;
    seg_d    = {~(mode_q & (scan_idx_q == cursor_q)), hex_seg(disp_val)};
    for (int i = 0; i < N_DIG; i++) begin
      dig_sel_d[i] = (disp_idx != CW'(i));
    end
  end

  // Edit, scan and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      cursor_q   <= '0;
      mode_q     <= 1'b0;
      digs_q     <= '0;
      seg_q      <= 8'hFF;
      dig_sel_q  <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      cursor_q   <= cursor_d;
      mode_q     <= mode_d;
      digs_q     <= digs_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign cursor  = cursor_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_key_scan_mux.sv
// tb/tb_key_scan_mux.sv - self-checking bench for key_scan_mux
module tb_key_scan_mux;

  localparam int N_KEY      = 4;
  localparam int N_DIG      = 4;
  localparam int DEB_CYC    = 4;
  localparam int SCAN_DIV   = 2;
  localparam int REP_DELAY  = 20;
  localparam int REP_PERIOD = 6;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] key_data = 4'hF;
  logic       key_next = 1'b1;
  logic       key_mode = 1'b1;
  logic [7:0] seg;
  logic [3:0] dig_sel;
  logic [1:0] cursor;
  logic       mode;

  key_scan_mux #(
    .N_KEY(N_KEY), .N_DIG(N_DIG), .DEB_CYC(DEB_CYC), .SCAN_DIV(SCAN_DIV),
    .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_data(key_data), .key_next(key_next),
    .key_mode(key_mode), .seg(seg), .dig_sel(dig_sel), .cursor(cursor), .mode(mode)
  );

  always #5 clk = ~clk;

  // Active-high a..g patterns for 0-F.
  localparam logic [7:0] SEG_ON [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the user has entered so far.
  int exp_cursor = 0;
  int exp_mode   = 0;
  int exp_dig [N_DIG];
  int cur_val    = 0;

  function automatic logic [7:0] glyph(input int v, input bit dp_lit);
    logic [7:0] on;
    on    = SEG_ON[v & 15];
    on[7] = dp_lit;
    return ~on;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int v);
    logic [3:0] v4;
    v4 = v[3:0];
    key_data = ~v4;
    cur_val  = v;
    cyc(8);
  endtask

  task automatic advance_model(input int v);
    exp_dig[exp_cursor] = v;
    exp_cursor = (exp_cursor + 1) % N_DIG;
  endtask

  task automatic press_next(input int v, input int hold);
    set_data(v);
    key_next = 1'b0;
    cyc(hold);
    key_next = 1'b1;
    cyc(12);
    if (hold >= DEB_CYC) advance_model(v);
  endtask

  task automatic press_mode();
    key_mode = 1'b0;
    cyc(8);
    key_mode = 1'b1;
    cyc(12);
    exp_mode = 1 - exp_mode;
  endtask

  task automatic check_edit_view(input string tag);
    logic [3:0] ds;
    ds = 4'hF;
    ds[exp_cursor] = 1'b0;
    chk({tag, "_cursor"}, cursor, exp_cursor);
    chk({tag, "_mode"}, mode, exp_mode);
    chk({tag, "_dig_sel"}, dig_sel, ds);
    chk({tag, "_seg"}, seg, glyph(cur_val, 1'b0));
  endtask

  task automatic scan_check(input string tag);
    int seq [16];
    int idx;
    int nlow;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      idx  = -1;
      nlow = 0;
      for (int b = 0; b < N_DIG; b++) begin
        if (!dig_sel[b]) begin
          idx = b;
          nlow++;
        end
      end
      chk({tag, "_onehot"}, nlow, 1);
      if (idx < 0) idx = 0;
      seq[s] = idx;
      chk({tag, "_seg"}, seg, glyph(exp_dig[idx], idx == exp_cursor));
    end
    for (int s = 0; s < 14; s++) begin
      chk({tag, "_step"}, seq[s+2], (seq[s] + 1) % N_DIG);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int h;
    int seen;
    int first;
    int n_adv;
    int exp_n;
    int rec_off [8];
    int exp_off [5];
    logic [1:0] prev;

    for (int i = 0; i < N_DIG; i++) exp_dig[i] = 0;
    exp_off = '{0, 20, 26, 32, 38};

    // Reset state.
    cyc(3);
    chk("reset_seg", seg, 8'hFF);
    chk("reset_dig_sel", dig_sel, 4'hF);
    chk("reset_cursor", cursor, 0);
    chk("reset_mode", mode, 0);

    // Reset release with no keys pressed.
    rst_n = 1'b1;
    cyc(2);
    chk("release_dig_sel", dig_sel, 4'b1110);
    chk("release_seg", seg, 8'hC0);
    chk("release_cursor", cursor, 0);
    chk("release_mode", mode, 0);

    // Short glitch on key_next is ignored, a held press stores 0xA.
    press_next(10, 3);
    check_edit_view("glitch");
    press_next(10, 10);
    check_edit_view("first_press");

    // Four presses walk the cursor around and wrap.
    for (int k = 0; k < 4; k++) begin
      press_next($urandom_range(0, 15), 10);
      check_edit_view("wrap");
    end

    // Debounce boundary: exactly DEB_CYC registers, one fewer does not.
    press_next($urandom_range(0, 15), DEB_CYC);
    check_edit_view("deb_exact");
    press_next($urandom_range(0, 15), DEB_CYC - 1);
    check_edit_view("deb_short");

    // Random values and hold lengths.
    for (int k = 0; k < 10; k++) begin
      v = $urandom_range(0, 15);
      h = $urandom_range(1, 10);
      press_next(v, h);
      check_edit_view("random");
    end

    // Simultaneous mode and next presses take effect on the same cycle.
    v = $urandom_range(0, 15);
    set_data(v);
    key_next = 1'b0;
    key_mode = 1'b0;
    seen = 0;
    for (int t = 0; t < 30 && seen == 0; t++) begin
      @(negedge clk);
      if (cursor != 2'(exp_cursor)) seen = 1;
    end
    chk("both_seen", seen, 1);
    chk("both_mode_same_cycle", mode, 1);
    key_next = 1'b1;
    key_mode = 1'b1;
    cyc(12);
    advance_model(v);
    exp_mode = 1;
    chk("both_cursor", cursor, exp_cursor);
    chk("both_mode", mode, exp_mode);

    // All-digit view shows stored digits with dp on the cursor.
    scan_check("scan");

    // Back to edit view.
    press_mode();
    check_edit_view("mode_back");

    // Auto-repeat behaviour on a long key_next hold.
    v = $urandom_range(0, 15);
    set_data(v);
    key_next = 1'b0;
    first = -1;
    n_adv = 0;
    prev  = cursor;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (cursor != prev) begin
        if (first < 0) first = t;
        if (n_adv < 8) rec_off[n_adv] = t - first;
        n_adv++;
        prev = cursor;
      end
      if (first >= 0 && t - first == 34) key_next = 1'b1;
      if (first >= 0 && t - first >= 60) break;
    end
    key_next = 1'b1;
    cyc(12);
`ifdef KEY_SCAN_MUX_AUTOREPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    chk("rep_count", n_adv, exp_n);
    for (int k = 0; k < exp_n && k < n_adv && k < 8; k++) begin
      chk("rep_offset", rec_off[k], exp_off[k]);
    end
    for (int k = 0; k < exp_n; k++) advance_model(v);
    check_edit_view("after_hold");

    // Reset during a held key_next discards it; the held key needs a fresh press.
    v = $urandom_range(0, 15);
    set_data(v);
    key_next = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    cyc(2);
    chk("midreset_seg", seg, 8'hFF);
    chk("midreset_dig_sel", dig_sel, 4'hF);
    chk("midreset_cursor", cursor, 0);
    chk("midreset_mode", mode, 0);
    for (int i = 0; i < N_DIG; i++) exp_dig[i] = 0;
    exp_cursor = 0;
    exp_mode   = 0;
    rst_n = 1'b1;
    cyc(20);
    chk("held_through_reset", cursor, 0);
    key_next = 1'b1;
    cyc(12);
    chk("released_after_reset", cursor, 0);
    press_next(v, 8);
    check_edit_view("repress");
    press_mode();
    scan_check("post_reset_scan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan_mux.md
KEY_SCAN_MUX -- requirements
Module: key_scan_mux

Interface
REQ-001 SHALL have parameter N_KEY, default 4: number of data keys forming a digit value; legal range 1..4.
REQ-002 SHALL have parameter N_DIG, default 8: number of multiplexed 7-segment digits; legal range 2..8.
REQ-003 SHALL have parameter DEB_CYC, default 1000000: clk cycles a raw key must stay stable before its debounced state changes.
REQ-004 SHALL have parameter SCAN_DIV, default 50000: clk cycles each digit stays selected.
REQ-005 SHALL have parameters REP_DELAY, default 25000000, and REP_PERIOD, default 5000000: auto-repeat timing in clk cycles (see REQ-024).
REQ-006 clk  input  1  system clock; all state is on posedge clk.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_data  input  N_KEY  raw data keys, active-low; key_data[N_KEY-1] is the MSB of the entered value.
REQ-009 key_next  input  1  raw key, active-low: store the value and advance the cursor.
REQ-010 key_mode  input  1  raw key, active-low: toggle the display mode.
REQ-011 seg  output  8  segments, active-low: seg[0]=a ... seg[6]=g, seg[7]=dp.
REQ-012 dig_sel  output  N_DIG  digit select, active-low, at most one bit low.
REQ-013 cursor  output  clog2(N_DIG)  index of the current edit digit.
REQ-014 mode  output  1  0=single-digit edit view, 1=all-digit view.

Function
REQ-015 Each raw key SHALL pass through a 2-flop synchronizer, then a per-key counter; debounced state SHALL take the synchronized value after DEB_CYC consecutive cycles differing from the current state, and the counter SHALL clear on any cycle where they match.
REQ-016 A press SHALL be a 1-cycle pulse on the debounced 1->0 transition; releases SHALL generate no pulse.
REQ-017 live value SHALL be the inverted debounced key_data, zero-extended to 4 bits.
REQ-018 On a key_next press, the cycle after the pulse SHALL show live value stored in digit register[cursor] and cursor incremented, wrapping N_DIG-1 -> 0.
REQ-019 On a key_mode press, mode SHALL toggle on the next cycle; simultaneous key_next and key_mode presses SHALL both take effect in the same cycle.
REQ-020 A scan counter SHALL count 0..SCAN_DIV-1; at wrap, scan index SHALL advance 0..N_DIG-1 and wrap to 0.
REQ-021 mode=1: dig_sel SHALL select the scan index and seg SHALL show the stored hex value of that digit (standard 0-F glyphs), with dp lit only when scan index == cursor.
REQ-022 mode=0: dig_sel SHALL select only the cursor digit, with dp off, and seg SHALL show the live value; all other digits SHALL be blanked.
REQ-023 seg and dig_sel SHALL be registered, updating one cycle after their sources change.

Configuration
REQ-024 With macro KEY_SCAN_MUX_AUTOREPEAT_EN defined, key_next held debounced-low SHALL generate an extra advance pulse REP_DELAY cycles after the press pulse and then every REP_PERIOD cycles until release; without the macro, exactly one advance SHALL occur per press and the repeat counter SHALL not exist.

Reset
REQ-025 While rst_n=0: seg=8'hFF, dig_sel all 1, cursor=0, mode=0, all digit registers=0, debounced states=1 (released), and all counters=0.
REQ-026 Reset asserted mid-debounce or mid-repeat SHALL discard the pending event; a key held through reset release SHALL NOT produce a press pulse until it is released and pressed again.

Verification (bench params N_KEY=4, N_DIG=4, DEB_CYC=4, SCAN_DIV=2, REP_DELAY=20, REP_PERIOD=6)
REQ-027 Reset release with no keys pressed -> cursor=0, mode=0, digit 0 selected with seg=8'hC0 ('0', dp off) within 2 cycles.
REQ-028 key_data=4'b0101 (value 0xA) held, key_next pulsed low 3 cycles then high -> no advance; key_next held 10 cycles -> cursor 0->1, digit0=0xA.
REQ-029 Four valid key_next presses -> cursor 1,2,3,0 (wrap).
REQ-030 key_mode and key_next pressed in the same cycle -> mode=1 and cursor+1 on the same cycle; in all-digit view, dig_sel steps 1110,1101,1011,0111 every 2 cycles, with dp low only on the cursor digit.
REQ-031 With KEY_SCAN_MUX_AUTOREPEAT_EN, key_next held 40 cycles after its press pulse -> 1 + 4 advances (at +0, +20, +26, +32, +38); without the macro -> 1 advance.
REQ-032 rst_n low during a held key_next -> all outputs at reset values; held key after release -> no advance until it is released and pressed again.
